// File: rtl/config_write_arbiter.sv
// Round-robin arbiter sharing one config write bus between N_REQ requesters.
// A requester that starts a multi-beat transaction holds the bus until its
// last beat. An optional idle gap after every write gives downstream config
// registers time to settle.
module config_write_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_BITS  = 64,
  parameter int unsigned DATA_BITS  = 64,
  parameter int unsigned GAP_CYCLES = 0,
  localparam int unsigned OwnerW    = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0][ADDR_BITS-1:0]     req_addr,
  input  logic [N_REQ-1:0][DATA_BITS-1:0]     req_data,
  input  logic [N_REQ-1:0]                    req_last,
  output logic                                cfg_valid,
  output logic [ADDR_BITS-1:0]                cfg_addr,
  output logic [DATA_BITS-1:0]                cfg_data,
  output logic                                busy,
  output logic [OwnerW-1:0]                   owner
);

  typedef enum logic [1:0] {StIdle, StLocked, StGap} state_e;

  state_e                 r_state, w_state_next;
  logic [7:0]             r_cnt, w_cnt_next;
  logic [OwnerW-1:0]      r_rr, r_owner, w_rr_next;
  logic                   r_last;
  logic                   r_cfg_valid, r_busy;
  logic [ADDR_BITS-1:0]   r_cfg_addr;
  logic [DATA_BITS-1:0]   r_cfg_data;

  logic                   w_found, w_found_hi;
  logic [OwnerW-1:0]      w_idx_hi, w_idx_lo, w_win, w_sel;
  logic                   w_grant, w_accept;

  // Round-robin search: lowest valid index at or above rr, else lowest valid overall.
  always_comb begin
    w_found    = 1'b0;
    w_found_hi = 1'b0;
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_found  = 1'b1;
        w_idx_lo = OwnerW'(i);
        if (i >= int'(r_rr)) begin
          w_found_hi = 1'b1;
          w_idx_hi   = OwnerW'(i);
        end
      end
    end
    w_win = w_found_hi ? w_idx_hi : w_idx_lo;
  end

  // Select the requester allowed to transfer and drive its ready bit.
  always_comb begin
    w_sel   = r_owner;
    w_grant = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_sel   = w_win;
        w_grant = w_found;
      end
      StLocked: w_grant = req_valid[r_owner];
      default:  w_grant = 1'b0;
    endcase
    // Ready is forced low while reset is asserted even though state already reads idle.
    w_accept  = rst_n & w_grant;
    req_ready = '0;
    if (w_accept) req_ready[w_sel] = 1'b1;
  end

  // Pointer moves to the requester after the one releasing the lock.
  always_comb begin
    w_rr_next = (w_sel == OwnerW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
  end

  // Next-state logic for lock and gap handling.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle, StLocked: begin
        if (w_accept) begin
          if (GAP_CYCLES > 0) begin
            w_state_next = StGap;
            w_cnt_next   = 8'(GAP_CYCLES);
          end else begin
            w_state_next = req_last[w_sel] ? StIdle : StLocked;
          end
        end
      end
      StGap: begin
        w_cnt_next = r_cnt - 8'd1;
        if (r_cnt <= 8'd1) w_state_next = r_last ? StIdle : StLocked;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State, gap counter and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
      r_rr    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_state_next != StIdle);
      if (w_accept && req_last[w_sel]) r_rr <= w_rr_next;
    end
  end

  // Output write register; address/data hold when no beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_owner     <= '0;
      r_last      <= 1'b0;
    end else begin
      r_cfg_valid <= w_accept;
      if (w_accept) begin
        r_cfg_addr <= req_addr[w_sel];
        r_cfg_data <= req_data[w_sel];
        r_owner    <= w_sel;
        r_last     <= req_last[w_sel];
      end
    end
  end

  assign cfg_valid = r_cfg_valid;
  assign cfg_addr  = r_cfg_addr;
  assign cfg_data  = r_cfg_data;
  assign busy      = r_busy;
  assign owner     = r_owner;

endmodule

// File: tb/tb_config_write_arbiter.sv
// Directed bench: three arbiter instances (2 requesters no gap, 2 requesters
// gap of 3, 4 requesters no gap) sharing clock and reset.
module tb_config_write_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Instance A: N_REQ=2, GAP=0
  logic [1:0]        v2, l2, r2;
  logic [1:0][63:0]  a2, d2;
  logic              cv2, b2;
  logic [63:0]       ca2, cd2;
  logic [0:0]        o2;

  // Instance G: N_REQ=2, GAP=3
  logic [1:0]        vg, lg, rg;
  logic [1:0][63:0]  ag, dg;
  logic              cvg, bg;
  logic [63:0]       cag, cdg;
  logic [0:0]        og;

  // Instance W: N_REQ=4, GAP=0
  logic [3:0]        v4, l4, r4;
  logic [3:0][63:0]  a4, d4;
  logic              cv4, b4;
  logic [63:0]       ca4, cd4;
  logic [1:0]        o4;

  config_write_arbiter #(.N_REQ(2), .ADDR_BITS(64), .DATA_BITS(64), .GAP_CYCLES(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(r2), .req_addr(a2), .req_data(d2),
    .req_last(l2), .cfg_valid(cv2), .cfg_addr(ca2), .cfg_data(cd2), .busy(b2), .owner(o2)
  );

  config_write_arbiter #(.N_REQ(2), .ADDR_BITS(64), .DATA_BITS(64), .GAP_CYCLES(3)) u_gap (
    .clk(clk), .rst_n(rst_n), .req_valid(vg), .req_ready(rg), .req_addr(ag), .req_data(dg),
    .req_last(lg), .cfg_valid(cvg), .cfg_addr(cag), .cfg_data(cdg), .busy(bg), .owner(og)
  );

  config_write_arbiter #(.N_REQ(4), .ADDR_BITS(64), .DATA_BITS(64), .GAP_CYCLES(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(r4), .req_addr(a4), .req_data(d4),
    .req_last(l4), .cfg_valid(cv4), .cfg_addr(ca4), .cfg_data(cd4), .busy(b4), .owner(o4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v2 = 2'b11; l2 = 2'b11; a2 = '0; d2 = '0;
    vg = 2'b11; lg = 2'b11; ag = '0; dg = '0;
    v4 = 4'b1111; l4 = 4'b1111; a4 = '0; d4 = '0;

    // Reset held with requests pending
    for (int i = 0; i < 5; i++) tick();
    check("rst_ready2", 64'(r2), 64'h0);
    check("rst_ready4", 64'(r4), 64'h0);
    check("rst_readyg", 64'(rg), 64'h0);
    check("rst_cfg_valid", 64'(cv2), 64'h0);
    check("rst_busy", 64'(b2), 64'h0);
    check("rst_owner", 64'(o2), 64'h0);
    check("rst_cfg_addr", ca2, 64'h0);

    // Round robin with single beats
    a2[0] = 64'h10; d2[0] = 64'h10;
    a2[1] = 64'h20; d2[1] = 64'h20;
    vg = 2'b00; v4 = 4'b0000;
    rst_n = 1'b1;
    #1;
    check("rr_first_ready", 64'(r2), 64'h1);
    tick();
    check("rr_v0", 64'(cv2), 64'h1);
    check("rr_a0", ca2, 64'h10);
    check("rr_own0", 64'(o2), 64'h0);
    check("rr_ready1", 64'(r2), 64'h2);
    a2[0] = 64'h18; d2[0] = 64'h18;
    tick();
    check("rr_a1", ca2, 64'h20);
    check("rr_own1", 64'(o2), 64'h1);
    check("rr_ready2", 64'(r2), 64'h1);
    a2[1] = 64'h28; d2[1] = 64'h28;
    tick();
    check("rr_a2", ca2, 64'h18);
    check("rr_v2", 64'(cv2), 64'h1);
    tick();
    check("rr_a3", ca2, 64'h28);
    check("rr_busy", 64'(b2), 64'h0);
    v2 = 2'b00;
    tick();
    check("hold_valid", 64'(cv2), 64'h0);
    check("hold_addr", ca2, 64'h28);

    // Burst lock: req0 three beats with req1 waiting, stall mid-burst
    v2 = 2'b11;
    d2[0] = 64'hA; a2[0] = 64'h100; l2[0] = 1'b0;
    d2[1] = 64'h99; a2[1] = 64'h200; l2[1] = 1'b1;
    #1;
    check("bl_ready0", 64'(r2), 64'h1);
    tick();
    check("bl_dA", cd2, 64'hA);
    check("bl_busy", 64'(b2), 64'h1);
    check("bl_locked_ready", 64'(r2), 64'h1);
    d2[0] = 64'hB;
    tick();
    check("bl_dB", cd2, 64'hB);
    check("bl_vB", 64'(cv2), 64'h1);
    d2[0] = 64'hC; l2[0] = 1'b1;
    v2 = 2'b10;
    #1;
    check("stall_ready", 64'(r2), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", 64'(cv2), 64'h0);
      check("stall_busy", 64'(b2), 64'h1);
      check("stall_ready", 64'(r2), 64'h0);
    end
    v2 = 2'b11;
    tick();
    check("bl_dC", cd2, 64'hC);
    check("bl_vC", 64'(cv2), 64'h1);
    check("bl_next_ready", 64'(r2), 64'h2);
    v2 = 2'b10;
    tick();
    check("bl_req1", cd2, 64'h99);
    check("bl_own1", 64'(o2), 64'h1);
    v2 = 2'b00;
    tick();

    // Gap of three cycles between writes
    vg = 2'b01; ag[0] = 64'h100; dg[0] = 64'h1; lg[0] = 1'b0;
    tick();
    check("gap_v1", 64'(cvg), 64'h1);
    check("gap_a1", cag, 64'h100);
    check("gap_busy", 64'(bg), 64'h1);
    check("gap_ready", 64'(rg), 64'h0);
    ag[0] = 64'h104; dg[0] = 64'h2; lg[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("gap_idle_valid", 64'(cvg), 64'h0);
      check("gap_idle_ready", 64'(rg), 64'h0);
      check("gap_idle_busy", 64'(bg), 64'h1);
    end
    tick();
    check("gap_end_valid", 64'(cvg), 64'h0);
    check("gap_end_ready", 64'(rg), 64'h1);
    tick();
    check("gap_v2", 64'(cvg), 64'h1);
    check("gap_a2", cag, 64'h104);
    vg = 2'b00;
    tick();
    tick();
    check("gap2_busy", 64'(bg), 64'h1);
    tick();
    check("gap2_done", 64'(bg), 64'h0);

    // Reset in the middle of req1's burst
    v2 = 2'b10; d2[1] = 64'h51; l2[1] = 1'b0; d2[0] = 64'h61; l2[0] = 1'b1;
    tick();
    check("mid_d1", cd2, 64'h51);
    check("mid_busy", 64'(b2), 64'h1);
    check("mid_own", 64'(o2), 64'h1);
    v2 = 2'b11;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(cv2), 64'h0);
    check("mid_rst_busy", 64'(b2), 64'h0);
    check("mid_rst_ready", 64'(r2), 64'h0);
    check("mid_rst_own", 64'(o2), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 64'(r2), 64'h1);
    tick();
    check("mid_first", cd2, 64'h61);
    check("mid_first_own", 64'(o2), 64'h0);
    v2 = 2'b00;

    // Four-requester wrap
    for (int i = 0; i < 4; i++) begin
      a4[i] = 64'(32'h40 + i);
      d4[i] = 64'(32'h80 + i);
    end
    v4 = 4'b1111; l4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("wrap_owner", 64'(o4), 64'(k % 4));
      check("wrap_addr", ca4, 64'(32'h40 + (k % 4)));
      check("wrap_valid", 64'(cv4), 64'h1);
    end
    v4 = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
